uart_transmitter: RTL and testbench
===================================

Name: uart_transmitter

Overview:
8N1 UART serial transmitter that is the upstream partner of uart_receiver: it drives the serial line that the receiver samples on its dataValue input. A parallel producer pushes bytes through a valid/ready handshake into a small FIFO. The transmitter serialises each byte LSB-first with one start bit and STOP_BITS stop bits, at the same baud timing the receiver uses. Used for loopback test benches and board-to-host transmit.

Parameters:
CLK_FREQ, 100_000_000, frequency of clk_1MHz in Hz
BAUD_RATE, 9600, line rate in bits/s
BIT_PERIOD, CLK_FREQ/BAUD_RATE (10416), clock cycles per serial bit; must be < 65536
FIFO_DEPTH, 4, byte entries in input FIFO; power of 2, >= 2
STOP_BITS, 1, stop bits per frame (1 or 2)

Ports:
clk_1MHz  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
in_data  input  8  byte to transmit
in_valid  input  1  producer offers in_data this cycle
in_ready  output  1  FIFO can accept; push occurs on in_valid & in_ready at the clock edge
tx  output  1  serial line, idle high, registered
busy  output  1  high while a frame is on the line (START, DATA or STOP state)
fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently queued, excluding the byte being sent

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk_1MHz.
- Reset values: tx=1, busy=0, fifo_count=0, in_ready=1, state=IDLE, bit counter=0, baud counter=0. FIFO pointers are cleared; queued bytes are discarded.
- in_ready = (fifo_count != FIFO_DEPTH), combinational from registered count. A push while full is ignored and not stored.
- Pop and push in the same cycle: count is unchanged and both take effect. Push is still refused if count was FIFO_DEPTH at the start of that cycle.
- Baud counter: 16-bit, counts 0..BIT_PERIOD-1. The bit boundary is when count == BIT_PERIOD-1; the counter then wraps to 0.
- States:
  - IDLE: tx=1, busy=0. If FIFO is non-empty, pop the head into the shift register, clear counters, go to START. The first start-bit cycle on tx is 1 cycle after the pop edge.
  - START: tx=0 for exactly BIT_PERIOD cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for BIT_PERIOD cycles per bit. At each boundary, shift right and increment the bit index. After bit index 7 completes, go to STOP.
  - STOP: tx=1 for STOP_BITS*BIT_PERIOD cycles. At the final boundary:
    - FIFO non-empty: pop and go directly to START, with no idle gap between frames.
    - FIFO empty: go to IDLE.
- Frame length: (9+STOP_BITS)*BIT_PERIOD cycles exactly, i.e. 104160 cycles for defaults.
- Latency: a push into an empty FIFO while IDLE gives a tx falling edge 2 cycles after the push edge (push edge, pop edge, then tx register update).
- tx is driven only from the state register and shift register. It must be glitch-free, with no combinational path from in_valid or in_data.
- in_data is captured at the push edge. Later changes on in_data do not affect queued or in-flight bytes.
- Reset mid-frame:
  - tx=1 from the edge where rst is sampled high.
  - The partial frame is abandoned; no resumption after rst falls.
  - The first cycle after reset is IDLE.
- fifo_count wraps never: it saturates by construction, because a push is refused when full.

Test Plan:
- Single byte 0xA5 pushed after reset: tx=0 for 10416 cycles, then bits 1,0,1,0,0,1,0,1 at 10416 cycles each, then tx=1. busy is high for 104160 cycles, then IDLE.
- Push 0x55 then 0x0F on consecutive cycles: second start bit begins on the cycle after the first stop bit ends, no idle gap. fifo_count goes 0→1→1(pop+push)→… →0 after the second pop.
- Hold in_valid for 7 cycles with values 0x01..0x07 while the line is busy: 1 byte in flight and FIFO_DEPTH=4 queued. in_ready drops once fifo_count=4; bytes 0x06 and 0x07 are dropped. Transmitted sequence is 0x01..0x05.
- Full FIFO, push coincident with pop at the stop-bit boundary: push refused, fifo_count goes 4→3, in_ready rises the next cycle.
- Assert rst for 1 cycle during DATA bit 3 of 0xC3, with 2 bytes queued: tx=1 the next cycle, busy=0, fifo_count=0. No further frames follow.
- Loopback: tx connected to uart_receiver dataValue, both on the same clock and defaults. Send 0x3C and then 0xF0 back-to-back: receiver data shows 0x3C, then 0xF0 after the second frame's stop bit.

Source files
------------

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: a small byte FIFO feeds a start/data/stop serialiser.
// tx is registered from the FSM state and the shift register, so producer inputs never reach the line combinationally.
module uart_transmitter #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int BIT_PERIOD = CLK_FREQ / BAUD_RATE,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic                          clk_1MHz,
    input  logic                          rst,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [15:0]   BIT_LAST   = 16'(BIT_PERIOD - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic          STOP_LAST  = 1'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          fifo_empty;

    state_t        state;
    state_t        state_next;
    logic [15:0]   baud_cnt;
    logic [15:0]   baud_next;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_next;
    logic          stop_idx;
    logic          stop_next;
    logic [7:0]    shift;
    logic [7:0]    shift_next;
    logic          boundary;
    logic          tx_next;

    // Full is judged on the registered count, so a pop in the same cycle never frees a slot early.
    assign in_ready   = (fifo_count != FULL_COUNT);
    assign push       = in_valid & in_ready;
    assign fifo_empty = (fifo_count == CW'(0));
    assign boundary   = (baud_cnt == BIT_LAST);

    // FIFO storage: data is captured at the push edge only.
    always_ff @(posedge clk_1MHz) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk_1MHz) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Next-state, counter and pop decode for the serialiser.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_idx;
        stop_next  = stop_idx;
        shift_next = shift;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                baud_next = 16'd0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr];
                    bit_next   = 3'd0;
                    stop_next  = 1'b0;
                    state_next = START;
                end else begin
                    state_next = IDLE;
                end
            end
            START: begin
                if (boundary) begin
                    baud_next  = 16'd0;
                    bit_next   = 3'd0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_cnt + 16'd1;
                end
            end
            DATA: begin
                if (boundary) begin
                    baud_next  = 16'd0;
                    shift_next = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        stop_next  = 1'b0;
                        state_next = STOP;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end else begin
                    baud_next = baud_cnt + 16'd1;
                end
            end
            STOP: begin
                if (boundary) begin
                    baud_next = 16'd0;
                    if (stop_idx == STOP_LAST) begin
                        // Back-to-back frames: reload straight into START with no idle bit.
                        if (!fifo_empty) begin
                            pop        = 1'b1;
                            shift_next = mem[rd_ptr];
                            bit_next   = 3'd0;
                            stop_next  = 1'b0;
                            state_next = START;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        stop_next = 1'b1;
                    end
                end else begin
                    baud_next = baud_cnt + 16'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Line level for the current state; lands on tx one cycle later.
    always_comb begin
        tx_next = 1'b1;
        case (state)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift[0];
            default: tx_next = 1'b1;
        endcase
    end

    // Serialiser state register.
    always_ff @(posedge clk_1MHz) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            stop_idx <= 1'b0;
            shift    <= 8'd0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_idx  <= bit_next;
            stop_idx <= stop_next;
            shift    <= shift_next;
        end
    end

    // Registered line and busy outputs; reset forces the line idle at once.
    always_ff @(posedge clk_1MHz) begin
        if (rst) begin
            tx   <= 1'b1;
            busy <= 1'b0;
        end else begin
            tx   <= tx_next;
            busy <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter with a short bit period: directed table, corner sequences,
// and randomized traffic checked cycle by cycle against a frame-schedule model plus a line decoder.
module tb_uart_transmitter;

    localparam int BP    = 8;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * BP;

    logic       clk_1MHz = 1'b0;
    logic       rst      = 1'b1;
    logic [7:0] in_data  = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;

    uart_transmitter #(
        .CLK_FREQ  (64),
        .BAUD_RATE (8),
        .FIFO_DEPTH(DEPTH),
        .STOP_BITS (1)
    ) dut (
        .clk_1MHz  (clk_1MHz),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .tx        (tx),
        .busy      (busy),
        .fifo_count(fifo_count)
    );

    always #5 clk_1MHz = ~clk_1MHz;

    int tests  = 0;
    int failed = 0;

    // Model: bytes waiting, bytes handed to the line, cycles left in the current frame.
    logic [7:0] q[$];
    logic [7:0] sent[$];
    logic [7:0] cur = 8'h00;
    int         rem = 0;

    // Line decoder state.
    bit         dec_active = 1'b0;
    int         dec_t      = 0;
    logic [7:0] dec_byte   = 8'h00;
    logic       prev_tx    = 1'b1;

    typedef struct {
        logic       rst;
        logic       valid;
        logic [7:0] data;
        logic       exp_ready;
        logic [2:0] exp_count;
        logic       exp_busy;
        logic       exp_tx;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame position -> line level: start bit, eight data bits LSB first, then stop.
    function automatic logic line_bit(input int r, input logic [7:0] b);
        int idx;
        if (r == 0) return 1'b1;
        idx = (FRAME - r) / BP;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        return 1'b1;
    endfunction

    task automatic tick();
        logic etx;
        bit   full;
        bit   do_pop;
        @(posedge clk_1MHz);
        if (rst) begin
            q.delete();
            sent.delete();
            rem = 0;
            etx = 1'b1;
        end else begin
            etx    = line_bit(rem, cur);
            full   = (q.size() == DEPTH);
            do_pop = (q.size() != 0) && (rem <= 1);
            if (do_pop) begin
                cur = q.pop_front();
                sent.push_back(cur);
                rem = FRAME;
            end else if (rem > 0) begin
                rem--;
            end
            if (in_valid && !full) q.push_back(in_data);
        end
        #1;
        chk("tx", 32'(tx), 32'(etx));
        chk("busy", 32'(busy), 32'(rem != 0));
        chk("fifo_count", 32'(fifo_count), 32'(q.size()));
        chk("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
        if (rst) begin
            dec_active = 1'b0;
            prev_tx    = 1'b1;
        end else begin
            if (dec_active) begin
                dec_t++;
                if ((dec_t % BP) == BP / 2 && dec_t / BP >= 1 && dec_t / BP <= 8)
                    dec_byte[dec_t / BP - 1] = tx;
                if (dec_t == 9 * BP + BP / 2) begin
                    chk("rx_stop", 32'(tx), 32'd1);
                    if (sent.size() == 0) begin
                        chk("rx_extra", 32'(dec_byte), 32'hFFFF_FFFF);
                    end else begin
                        chk("rx_byte", 32'(dec_byte), 32'(sent.pop_front()));
                    end
                    dec_active = 1'b0;
                end
            end else if (prev_tx && !tx) begin
                dec_active = 1'b1;
                dec_t      = 0;
            end
            prev_tx = tx;
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int i = 0; i < budget && (rem != 0 || q.size() != 0); i++) tick();
        chk(name, 32'(rem != 0 || q.size() != 0), 32'd0);
    endtask

    initial begin
        int busy_seen;

        vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 3'd1, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 8'h55, 1'b1, 3'd1, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 8'h66, 1'b1, 3'd2, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 8'h77, 1'b1, 3'd3, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 8'h88, 1'b0, 3'd4, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 8'h99, 1'b0, 3'd4, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 3'd4, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 3'd4, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 3'd4, 1'b1, 1'b1};

        // Directed: reset, push into empty FIFO, fill to full, refused push, first bits.
        for (int i = 0; i < 12; i++) begin
            rst      = vecs[i].rst;
            in_valid = vecs[i].valid;
            in_data  = vecs[i].data;
            tick();
            chk($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(vecs[i].exp_ready));
            chk($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(vecs[i].exp_count));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            chk($sformatf("vec%0d_tx", i), 32'(tx), 32'(vecs[i].exp_tx));
        end
        in_valid = 1'b0;

        // Full FIFO, push coincident with the pop at the stop boundary: refused.
        for (int i = 0; i < 200 && rem != 1; i++) tick();
        chk("reach_boundary", 32'(rem), 32'd1);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        tick();
        chk("full_pop_count", 32'(fifo_count), 32'd3);
        chk("full_pop_ready", 32'(in_ready), 32'd1);
        tick();
        chk("no_gap_tx", 32'(tx), 32'd0);
        chk("refill_count", 32'(fifo_count), 32'd4);
        in_valid = 1'b0;
        wait_idle("drain1", 1000);
        for (int i = 0; i < 20; i++) tick();
        chk("rx_all1", 32'(sent.size()), 32'd0);

        // Reset during data bit 3 of 0xC3 with two bytes queued.
        in_valid = 1'b1;
        in_data  = 8'hC3;
        tick();
        in_data  = 8'h11;
        tick();
        in_data  = 8'h22;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 200 && rem != FRAME - (4 * BP + 2); i++) tick();
        chk("reach_bit3", 32'(rem), 32'(FRAME - (4 * BP + 2)));
        rst = 1'b1;
        tick();
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        rst       = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (busy || !tx) busy_seen++;
        end
        chk("post_rst_quiet", 32'(busy_seen), 32'd0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 999) == 0);
            in_valid = ($urandom_range(0, 2) == 0);
            in_data  = 8'($urandom());
            tick();
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        wait_idle("drain2", 2000);
        for (int i = 0; i < 20; i++) tick();
        chk("rx_all2", 32'(sent.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
